// File: rtl/pipelined_var_shifter.sv
// Two-stage variable shift/rotate (LSL, LSR, ASR, ROR) on a WIDTH-bit word; 2-cycle latency, 1 beat/cycle.
// Valid/ready on both sides with no skid buffer: in_ready is combinational from out_ready.
module pipelined_var_shifter #(
   parameter int WIDTH   = 8,
   parameter int SHAMT_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [SHAMT_W-1:0] in_shamt,
   input  logic [1:0]         in_mode,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic               out_zero
);

   localparam int LG = $clog2(WIDTH);
   localparam int LO = LG / 2;

   typedef enum logic [1:0] {
      LSL = 2'b00,
      LSR = 2'b01,
      ASR = 2'b10,
      ROR = 2'b11
   } mode_e;

   typedef struct packed {
      logic [WIDTH-1:0] data;
      mode_e            mode;
      logic [LO-1:0]    rest;
   } s1_t;

   // One shift layer by a fixed, nonzero distance s.
   function automatic logic [WIDTH-1:0] layer(input logic [WIDTH-1:0] d,
                                              input mode_e m, input int s);
      case (m)
         LSL:     return d << s;
         LSR:     return d >> s;
         ASR:     return $signed(d) >>> s;
         default: return (d >> s) | (d << (WIDTH - s));
      endcase
   endfunction

   logic             s1_valid;
   s1_t              s1;
   s1_t              s1_nxt;
   logic [WIDTH-1:0] s2_nxt;
   logic             s2_ready;
   logic             ovf;

   assign s2_ready = !out_valid || out_ready;
   assign in_ready = !s1_valid || s2_ready;

   always_comb begin
      s1_nxt.data = in_data;
      s1_nxt.mode = mode_e'(in_mode);
      s1_nxt.rest = in_shamt[LO-1:0];
      for (int k = LO; k < LG; k++)
         if (in_shamt[k]) s1_nxt.data = layer(s1_nxt.data, mode_e'(in_mode), 1 << k);
      ovf = |in_shamt[SHAMT_W-1:LG];
      // Overflowed shifts saturate here; clearing the residual keeps stage 2 a no-op.
      if (ovf && mode_e'(in_mode) != ROR) begin
         s1_nxt.rest = '0;
         s1_nxt.data = (mode_e'(in_mode) == ASR) ? {WIDTH{in_data[WIDTH-1]}} : '0;
      end
   end

   always_comb begin
      s2_nxt = s1.data;
      for (int k = 0; k < LO; k++)
         if (s1.rest[k]) s2_nxt = layer(s2_nxt, s1.mode, 1 << k);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s1        <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_zero  <= 1'b0;
      end else begin
         if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) s1 <= s1_nxt;
         end
         if (s2_ready) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
               out_data <= s2_nxt;
               out_zero <= ~|s2_nxt;
            end
         end
      end
   end

endmodule

// File: tb/tb_pipelined_var_shifter.sv
// Bench for pipelined_var_shifter: directed cases plus random traffic against a scoreboard.
module tb_pipelined_var_shifter;
   localparam int W  = 8;
   localparam int SW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_data = '0;
   logic [SW-1:0] in_shamt = '0;
   logic [1:0]    in_mode = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [W-1:0]  out_data;
   logic          out_zero;

   always #5 clk = ~clk;

   pipelined_var_shifter #(.WIDTH(W), .SHAMT_W(SW)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_shamt(in_shamt), .in_mode(in_mode),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_zero(out_zero)
   );

   typedef struct {
      logic [W-1:0] d;
      int           acc;
      bit           lat;
   } exp_t;

   exp_t         sb[$];
   int           errors = 0;
   int           checks = 0;
   int           cyc = 0;
   int           n_acc = 0;
   bit           lat_mode = 1'b0;
   bit           rnd_rdy = 1'b0;
   bit           done4 = 1'b0;
   bit           prev_stall = 1'b0;
   logic [W-1:0] prev_data = '0;
   logic [15:0]  cov_sh = '0;
   logic [3:0]   cov_m = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Behavioural model: plain integer arithmetic from the amount rules.
   function automatic logic [W-1:0] ref_model(input logic [W-1:0] d, input logic [SW-1:0] sh,
                                              input logic [1:0] m);
      int n, v, sv, r, mask;
      n    = int'(sh);
      v    = int'(d);
      sv   = d[W-1] ? v - (1 << W) : v;
      mask = (1 << W) - 1;
      r    = n % W;
      case (m)
         2'd0:    return (n >= W) ? '0 : W'((v << n) & mask);
         2'd1:    return (n >= W) ? '0 : W'(v >> n);
         2'd2:    return (n >= W) ? (d[W-1] ? '1 : '0) : W'((sv >>> n) & mask);
         default: return W'(((v >> r) | (v << (W - r))) & mask);
      endcase
   endfunction

   task automatic send(input logic [W-1:0] d, input logic [SW-1:0] sh, input logic [1:0] m);
      bit   ok;
      exp_t e;
      ok       = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      in_shamt = sh;
      in_mode  = m;
      for (int t = 0; t < 1000 && !ok; t++) begin
         @(negedge clk);
         if (in_ready && !rst) begin
            e.d   = ref_model(d, sh, m);
            e.acc = cyc;
            e.lat = lat_mode;
            sb.push_back(e);
            n_acc++;
            cov_sh[sh] = 1'b1;
            cov_m[m]   = 1'b1;
            ok = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      if (!ok) chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
      in_data  = W'($urandom);
      in_shamt = SW'($urandom);
      in_mode  = 2'($urandom);
   endtask

   // Monitor: pops the scoreboard on every output transfer.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         sb.delete();
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) chk("stall_hold", int'(out_data), int'(prev_data));
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_beat", int'(out_data), -1);
            end else begin
               e = sb.pop_front();
               chk("data", int'(out_data), int'(e.d));
               chk("zero", int'(out_zero), int'(e.d == '0));
               if (e.lat) chk("latency", cyc - e.acc, 2);
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
      end
   end

   always @(posedge clk) begin
      if (rnd_rdy) begin
         #1;
         out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   initial begin
      int base;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_out_valid", int'(out_valid), 0);
      chk("reset_out_data", int'(out_data), 0);
      chk("reset_out_zero", int'(out_zero), 0);
      chk("reset_in_ready", int'(in_ready), 1);
      @(posedge clk);
      #1;

      // Basic shifts, rotates, zero amounts and overflow, with latency tracking.
      lat_mode = 1'b1;
      send(8'hB6, 4'd2, 2'd0);
      send(8'hB6, 4'd2, 2'd1);
      send(8'hB6, 4'd2, 2'd2);
      send(8'hB6, 4'd3, 2'd3);
      send(8'hB6, 4'd11, 2'd3);
      for (int m = 0; m < 4; m++) send(8'hB6, 4'd0, 2'(m));
      send(8'hB6, 4'd8, 2'd0);
      send(8'h80, 4'd9, 2'd2);
      send(8'h7F, 4'd15, 2'd2);
      send(8'h81, 4'd8, 2'd1);
      send(8'h5A, 4'd8, 2'd3);
      repeat (4) @(posedge clk);
      #1;
      lat_mode = 1'b0;

      // Back-pressure: only two beats fit while the output stalls.
      out_ready = 1'b0;
      base  = n_acc;
      done4 = 1'b0;
      fork
         begin
            for (int i = 1; i <= 4; i++) send(W'(i), 4'd1, 2'd0);
            done4 = 1'b1;
         end
      join_none
      repeat (5) @(negedge clk);
      chk("bp_accepted", n_acc - base, 2);
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_hold_data", int'(out_data), 2);
      @(posedge clk);
      #1 out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("bp_order_valid", int'(out_valid), 1);
         chk("bp_order_data", int'(out_data), 2 * (i + 1));
      end
      for (int t = 0; t < 100 && !done4; t++) @(posedge clk);
      chk("bp_done", int'(done4), 1);
      repeat (3) @(posedge clk);
      #1;

      // Reset with two beats in flight: nothing may come out afterwards.
      out_ready = 1'b0;
      send(8'h11, 4'd1, 2'd0);
      send(8'h22, 4'd1, 2'd0);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_data", int'(out_data), 0);
      chk("rst_out_zero", int'(out_zero), 0);
      chk("rst_in_ready", int'(in_ready), 1);
      @(posedge clk);
      #1 out_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1;

      // Random traffic with random output back-pressure and idle gaps.
      cov_sh  = '0;
      cov_m   = '0;
      rnd_rdy = 1'b1;
      for (int i = 0; i < 10000; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            @(posedge clk);
            #1;
         end
         send(W'($urandom), SW'($urandom), 2'($urandom));
      end
      rnd_rdy = 1'b0;
      @(posedge clk);
      #1 out_ready = 1'b1;
      for (int t = 0; t < 200 && sb.size() != 0; t++) @(posedge clk);
      repeat (2) @(negedge clk);
      chk("drain_empty", sb.size(), 0);
      chk("cov_shamt", int'(cov_sh), 16'hFFFF);
      chk("cov_mode", int'(cov_m), 4'hF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
